gpio_bus_arbiter: RTL and testbench

- Shares the single-register GPIO peripheral between two bus requesters (m0 = CPU, m1 = DMA/debug master).
- Per transaction: round-robin arbitration, address decode against the GPIO base, then a one-cycle write-enable or read-enable pulse to the GPIO block.
- Returns a registered acknowledge, read data and error flag to the granted requester.
- Sits between the masters and the GPIO register block, replacing the direct address-decoder hookup.

---
 rtl/gpio_arb_pkg.sv | 7 +
 rtl/rr_arbiter2.sv | 16 +
 rtl/gpio_bus_arbiter.sv | 104 ++++++++++
 tb/tb_gpio_bus_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared state encoding, default GPIO base address and requester indices
package gpio_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
  localparam logic [31:0] GPIO_BASE_DEF = 32'h4000_0000;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; the requester that was not granted last wins a tie
//   req_i        request vector, bit 0 = m0, bit 1 = m1
//   last_grant_i index granted in the previous transaction
//   grant_o      selected requester index (meaningful only when valid_o)
//   valid_o      at least one request present
module rr_arbiter2
  import gpio_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);
  assign valid_o = |req_i;
  assign grant_o = &req_i ? ~last_grant_i : req_i[M1];
endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares the GPIO register between two requesters, one 3-cycle transaction per grant
//   clk, reset_n                     clock, asynchronous active-low reset
//   mX_req/we/addr/wdata             requester X transaction, held until mX_ack
//   mX_ack/err/rdata                 one-cycle completion, decode-miss flag and read data
//   gpio_we/re/wdata, gpio_rdata     single-cycle enables and data to/from the GPIO block
//   grant, busy                      current/last granted index, transaction in flight
module gpio_bus_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] GPIO_BASE = ADDR_W'(GPIO_BASE_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic              gpio_we,
  output logic              gpio_re,
  output logic [31:0]       gpio_wdata,
  input  logic [31:0]       gpio_rdata,
  output logic              grant,
  output logic              busy
);
  state_e      state_q, state_d;
  logic        grant_q, grant_d, last_q, last_d, we_q, we_d, hit_q, hit_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic        arb_grant, arb_valid;
  rr_arbiter2 u_arb (
    .req_i       ({m1_req, m0_req}),
    .last_grant_i(last_q),
    .grant_o     (arb_grant),
    .valid_o     (arb_valid)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    hit_d   = hit_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (arb_valid) begin
        state_d = ACCESS;
        grant_d = arb_grant;
        we_d    = arb_grant ? m1_we : m0_we;
        hit_d   = (arb_grant ? m1_addr : m0_addr) == GPIO_BASE;
        wdata_d = arb_grant ? m1_wdata : m0_wdata;
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = hit_q && !we_q ? gpio_rdata : '0;
      end
      RESP: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= M0;
      last_q  <= M1;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // Outputs decode straight from registered state, so reset clears them asynchronously.
  assign gpio_we    = state_q == ACCESS && hit_q && we_q;
  assign gpio_re    = state_q == ACCESS && hit_q && !we_q;
  assign gpio_wdata = wdata_q;
  assign m0_ack     = state_q == RESP && grant_q == M0;
  assign m1_ack     = state_q == RESP && grant_q == M1;
  assign m0_err     = m0_ack && !hit_q;
  assign m1_err     = m1_ack && !hit_q;
  assign m0_rdata   = m0_ack ? rdata_q : '0;
  assign m1_rdata   = m1_ack ? rdata_q : '0;
  assign grant      = grant_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: scoreboard bench with a transaction-level GPIO model and random requesters
module tb_gpio_bus_arbiter;
  localparam logic [31:0] BASE = 32'h4000_0000;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  logic        clk = 1'b0, reset_n;
  logic        m0_req, m0_we, m0_ack, m0_err, m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        gpio_we, gpio_re, grant, busy;
  logic [31:0] gpio_wdata, gpio_rdata;
  logic [31:0] gpio_reg = '0;
  int vectors = 0, miscompares = 0;
  txn_t sq0[$], sq1[$], exp0[$], exp1[$];
  int   ack_log[$];
  always #5 clk = ~clk;
  gpio_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .gpio_we(gpio_we), .gpio_re(gpio_re), .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata),
    .grant(grant), .busy(busy)
  );
  // The GPIO register block the arbiter fronts.
  assign gpio_rdata = gpio_re ? gpio_reg : '0;
  always @(posedge clk) if (gpio_we) gpio_reg <= gpio_wdata;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wd;
    return t;
  endfunction
  function automatic txn_t rnd_txn();
    int r = $urandom_range(0, 9);
    logic [31:0] a = r < 6 ? BASE : r < 8 ? BASE ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
    return mk(1'($urandom_range(0, 1)), a, $urandom);
  endfunction
  // Monitor: transaction-level reference model (one GPIO word, accesses in ack order).
  int          cyc, first, we_cnt, re_cnt;
  logic        prev;
  logic [5:0]  hist;
  logic [31:0] last_wd, model = '0;
  txn_t        e;
  logic        hit;
  always @(negedge clk) begin
    if (!reset_n) begin
      cyc = 0; first = -1; prev = 1'b1; we_cnt = 0; re_cnt = 0; hist = '0; last_wd = '0;
    end else begin
      cyc++;
      hist = {hist[3:0], m1_req, m0_req};
      chk("enable_rules", {30'd0, gpio_we & gpio_re, (gpio_we | gpio_re) & ~busy}, 32'd0);
      chk("ack_quiet", {30'd0, m0_ack & m1_ack,
          (~m0_ack & (m0_err | (|m0_rdata))) | (~m1_ack & (m1_err | (|m1_rdata)))}, 32'd0);
      if (!busy) chk("wdata_hold", gpio_wdata, last_wd);
      we_cnt += int'(gpio_we);
      re_cnt += int'(gpio_re);
      for (int k = 0; k < 2; k++) if (k == 1 ? m1_ack : m0_ack) begin
        chk("pending_txn", k == 1 ? exp1.size() : exp0.size(), 32'd1);
        if ((k == 1 ? exp1.size() : exp0.size()) > 0) begin
          if (k == 1) e = exp1.pop_front(); else e = exp0.pop_front();
          hit = e.addr == BASE;
          chk("ack_latency", cyc - first, 32'd2);
          chk("grant_idx", {31'd0, grant}, k);
          chk("busy_resp", {31'd0, busy}, 32'd1);
          chk("err", {31'd0, k == 1 ? m1_err : m0_err}, {31'd0, !hit});
          chk("rdata", k == 1 ? m1_rdata : m0_rdata, hit && !e.we ? model : 32'd0);
          chk("we_pulses", we_cnt, {31'd0, hit && e.we});
          chk("re_pulses", re_cnt, {31'd0, hit && !e.we});
          if (hist[5:4] == 2'b11) chk("rr_order", k, {31'd0, !prev});
          if (hit && e.we) model = e.wdata;
          chk("gpio_contents", gpio_reg, model);
          last_wd = e.wdata;
        end
        prev = 1'(k);
        ack_log.push_back(k);
        we_cnt = 0;
        re_cnt = 0;
      end
      if (m0_ack || m1_ack) first = -1;
      else if (first < 0 && (m0_req || m1_req)) first = cyc;
    end
  end
  // Requester agents: each holds one transaction until it sees its ack.
  logic [1:0] act = '0, seen;
  int         dly[2] = '{0, 0}, wt[2] = '{0, 0};
  txn_t       cur[2];
  bit         rand_mode = 0;
  task automatic step();
    @(negedge clk);
    seen = {m1_ack, m0_ack};
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (act[k]) begin
        if (seen[k]) begin
          act[k] = 1'b0;
          dly[k] = rand_mode ? $urandom_range(0, 3) : 0;
        end else if (++wt[k] > 12) begin
          chk("ack_within_bound", wt[k], 32'd12);
          act[k] = 1'b0;
          if (k == 1 && exp1.size() > 0) void'(exp1.pop_front());
          if (k == 0 && exp0.size() > 0) void'(exp0.pop_front());
        end
      end
      if (!act[k]) begin
        cur[k] = rnd_txn();
        if (dly[k] > 0) dly[k]--;
        else if ((k == 1 ? sq1.size() : sq0.size()) > 0) begin
          if (k == 1) begin cur[1] = sq1.pop_front(); exp1.push_back(cur[1]); end
          else begin cur[0] = sq0.pop_front(); exp0.push_back(cur[0]); end
          act[k] = 1'b1;
          wt[k] = 0;
        end
      end
    end
    m0_req = act[0]; m0_we = cur[0].we; m0_addr = cur[0].addr; m0_wdata = cur[0].wdata;
    m1_req = act[1]; m1_we = cur[1].we; m1_addr = cur[1].addr; m1_wdata = cur[1].wdata;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || act != 2'b00) && n < lim) begin
      step();
      n++;
    end
    chk("drain_done", sq0.size() + sq1.size() + int'(act[0]) + int'(act[1]), 32'd0);
    step();
    step();
  endtask
  initial begin
    int n;
    reset_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    #3;
    chk("reset_flags", {24'd0, m0_ack, m1_ack, m0_err, m1_err, gpio_we, gpio_re, grant, busy}, 32'd0);
    chk("reset_data", m0_rdata | m1_rdata | gpio_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    // Write, read-back by the other master, then a decode miss.
    sq0.push_back(mk(1'b1, BASE, 32'hA5A5_0001));
    drain(50);
    sq1.push_back(mk(1'b0, BASE, 32'h0));
    drain(50);
    chk("gpio_after_write", gpio_reg, 32'hA5A5_0001);
    sq0.push_back(mk(1'b1, BASE + 32'd4, 32'h1234_5678));
    drain(50);
    chk("gpio_after_miss", gpio_reg, 32'hA5A5_0001);
    // Reset during the ACCESS cycle of a write.
    sq0.push_back(mk(1'b1, BASE, 32'hDEAD_BEEF));
    n = 0;
    while (!gpio_we && n < 20) begin step(); n++; end
    chk("reached_access", {31'd0, gpio_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_flags", {26'd0, gpio_we, gpio_re, m0_ack, m1_ack, busy, grant}, 32'd0);
    act = '0; dly = '{0, 0};
    sq0.delete(); sq1.delete(); exp0.delete(); exp1.delete();
    m0_req = 0; m1_req = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("gpio_after_abort", gpio_reg, 32'hA5A5_0001);
    // Simultaneous contention right after reset: expect 0,1,0,1.
    ack_log.delete();
    sq0.push_back(mk(1'b1, BASE, 32'h1111_1111));
    sq0.push_back(mk(1'b0, BASE, 32'h0));
    sq1.push_back(mk(1'b0, BASE, 32'h0));
    sq1.push_back(mk(1'b1, BASE, 32'h2222_2222));
    drain(60);
    chk("contention_acks", ack_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("contention_grant", ack_log[i], i % 2);
    // Randomized traffic.
    rand_mode = 1;
    for (int i = 0; i < 150; i++) begin
      sq0.push_back(rnd_txn());
      sq1.push_back(rnd_txn());
    end
    drain(5000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
